// File: rtl/gpu_raster_engine.sv
// APB-fed command FIFO driving a rasteriser for Bresenham lines and filled rectangles.
// Pixels leave on a valid/ready stream; coordinates and colour hold while stalled.
module gpu_raster_engine #(
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [31:0]        pAddr_i,
  input  logic [31:0]        pDataWrite_i,
  input  logic               pSel_i,
  input  logic               pEnable_i,
  input  logic               pWrite_i,
  output logic               pReady_o,
  output logic [31:0]        pDataRead_o,
  output logic [X_W-1:0]     x_o,
  output logic [Y_W-1:0]     y_o,
  output logic [COLOR_W-1:0] r_o,
  output logic [COLOR_W-1:0] g_o,
  output logic [COLOR_W-1:0] b_o,
  output logic               pixel_valid_o,
  input  logic               pixel_ready_i,
  output logic               busy_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = ((X_W > Y_W) ? X_W : Y_W) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLineSetup,
    StLine,
    StRectSetup,
    StRect
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [31:0]   head;

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = pSel_i & pEnable_i & pWrite_i & ~fifo_full;
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pDataWrite_i;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (!push && pop) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command fields
  // ---------------------------------------------------------------------------
  logic [3:0]         op;
  logic [X_W-1:0]     hx;
  logic [Y_W-1:0]     hy;
  logic [COLOR_W-1:0] hr, hg, hb;

  assign op = head[31:28];
  assign hx = head[X_W+Y_W-1:Y_W];
  assign hy = head[Y_W-1:0];
  assign hr = head[3*COLOR_W-1:2*COLOR_W];
  assign hg = head[2*COLOR_W-1:COLOR_W];
  assign hb = head[COLOR_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{pAddr_i, head};

  // ---------------------------------------------------------------------------
  // Raster state
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [X_W-1:0]     x1_q, x1_d, x2_q, x2_d;
  logic [Y_W-1:0]     y1_q, y1_d, y2_q, y2_d;
  logic [X_W-1:0]     cur_x_q, cur_x_d;
  logic [Y_W-1:0]     cur_y_q, cur_y_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic signed [CW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic signed [CW:0]   err_q, err_d, err_t;
  logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [X_W-1:0]     xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_W-1:0]     ymax_q, ymax_d;

  logic signed [CW-1:0] x1s, x2s, y1s, y2s, ddx, ddy, adx, ady;
  logic signed [CW+1:0] e2, dx_w, dy_w;
  logic                 step_x, step_y, beat;
  logic [X_W-1:0]       rxmin, rxmax;
  logic [Y_W-1:0]       rymin, rymax;

  assign x1s = {{(CW-X_W){1'b0}}, x1_q};
  assign x2s = {{(CW-X_W){1'b0}}, x2_q};
  assign y1s = {{(CW-Y_W){1'b0}}, y1_q};
  assign y2s = {{(CW-Y_W){1'b0}}, y2_q};
  assign ddx = x2s - x1s;
  assign ddy = y2s - y1s;
  assign adx = ddx[CW-1] ? -ddx : ddx;
  assign ady = ddy[CW-1] ? -ddy : ddy;

  assign e2     = {err_q, 1'b0};
  assign dx_w   = {{2{dx_q[CW-1]}}, dx_q};
  assign dy_w   = {{2{dy_q[CW-1]}}, dy_q};
  assign step_x = (e2 > -dy_w);
  assign step_y = (e2 < dx_w);

  assign rxmin = (x1_q < x2_q) ? x1_q : x2_q;
  assign rxmax = (x1_q < x2_q) ? x2_q : x1_q;
  assign rymin = (y1_q < y2_q) ? y1_q : y2_q;
  assign rymax = (y1_q < y2_q) ? y2_q : y1_q;

  assign pixel_valid_o = (state_q == StLine) || (state_q == StRect);
  assign beat          = pixel_valid_o & pixel_ready_i;

  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymax_d   = ymax_q;
    pop      = 1'b0;
    err_t    = err_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          unique case (op)
            4'h1: begin
              x1_d = hx;
              y1_d = hy;
            end
            4'h2: begin
              x2_d = hx;
              y2_d = hy;
            end
            4'h4: begin
              r_d     = hr;
              g_d     = hg;
              b_d     = hb;
              state_d = StLineSetup;
            end
            4'h8: begin
              r_d     = hr;
              g_d     = hg;
              b_d     = hb;
              state_d = StRectSetup;
            end
            default: ;
          endcase
        end
      end

      StLineSetup: begin
        dx_d     = adx;
        dy_d     = ady;
        sx_neg_d = ddx[CW-1];
        sy_neg_d = ddy[CW-1];
        err_d    = {adx[CW-1], adx} - {ady[CW-1], ady};
        cur_x_d  = x1_q;
        cur_y_d  = y1_q;
        state_d  = StLine;
      end

      StLine: begin
        if (beat) begin
          if (cur_x_q == x2_q && cur_y_q == y2_q) begin
            state_d = StIdle;
          end else begin
            // Both tests use the pre-step error term.
            if (step_x) begin
              err_t   = err_t - {dy_q[CW-1], dy_q};
              cur_x_d = sx_neg_q ? cur_x_q - X_W'(1) : cur_x_q + X_W'(1);
            end
            if (step_y) begin
              err_t   = err_t + {dx_q[CW-1], dx_q};
              cur_y_d = sy_neg_q ? cur_y_q - Y_W'(1) : cur_y_q + Y_W'(1);
            end
            err_d = err_t;
          end
        end
      end

      StRectSetup: begin
        xmin_d  = rxmin;
        xmax_d  = rxmax;
        ymax_d  = rymax;
        cur_x_d = rxmin;
        cur_y_d = rymin;
        state_d = StRect;
      end

      StRect: begin
        if (beat) begin
          if (cur_x_q == xmax_q) begin
            if (cur_y_q == ymax_q) begin
              state_d = StIdle;
            end else begin
              cur_x_d = xmin_q;
              cur_y_d = cur_y_q + Y_W'(1);
            end
          end else begin
            cur_x_d = cur_x_q + X_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
    end else begin
      state_q  <= state_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymax_q   <= ymax_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign x_o      = cur_x_q;
  assign y_o      = cur_y_q;
  assign r_o      = r_q;
  assign g_o      = g_q;
  assign b_o      = b_q;
  assign busy_o   = (state_q != StIdle) | ~fifo_empty;
  assign pReady_o = ~fifo_full;

  always_comb begin
    pDataRead_o = '0;
    if (pSel_i && !pWrite_i) begin
      pDataRead_o = {16'b0, 8'(level_q), 6'b0, fifo_full, busy_o};
    end
  end

endmodule

// File: tb/tb_gpu_raster_engine.sv
// Directed bench for gpu_raster_engine: table of primitives with hand-computed pixel
// streams, plus sequences for FIFO-full wait states and mid-draw reset.
module tb_gpu_raster_engine;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] pAddr_i, pDataWrite_i;
  logic        pSel_i, pEnable_i, pWrite_i;
  logic        pReady_o;
  logic [31:0] pDataRead_o;
  logic [9:0]  x_o;
  logic [8:0]  y_o;
  logic [7:0]  r_o, g_o, b_o;
  logic        pixel_valid_o, pixel_ready_i, busy_o;

  always #5 clk = ~clk;

  gpu_raster_engine #(
    .X_W        (10),
    .Y_W        (9),
    .COLOR_W    (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .pAddr_i       (pAddr_i),
    .pDataWrite_i  (pDataWrite_i),
    .pSel_i        (pSel_i),
    .pEnable_i     (pEnable_i),
    .pWrite_i      (pWrite_i),
    .pReady_o      (pReady_o),
    .pDataRead_o   (pDataRead_o),
    .x_o           (x_o),
    .y_o           (y_o),
    .r_o           (r_o),
    .g_o           (g_o),
    .b_o           (b_o),
    .pixel_valid_o (pixel_valid_o),
    .pixel_ready_i (pixel_ready_i),
    .busy_o        (busy_o)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef struct {
    logic [31:0] xy1;
    logic [31:0] xy2;
    logic [31:0] cmd;
    int          off;
    int          n;
    bit          toggle;
  } prim_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_cyc, wr_cyc, got_n;
  pix_t  pool [29];
  prim_t prims [4];

  int l1x [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
  int l1y [13] = '{0, 1, 1, 2, 2, 3, 3, 4, 5, 5, 6, 6, 7};
  int l2x [8]  = '{5, 5, 4, 4, 4, 4, 3, 3};
  int l2y [8]  = '{9, 8, 7, 6, 5, 4, 3, 2};
  int rcx [6]  = '{2, 3, 4, 2, 3, 4};
  int rcy [6]  = '{3, 3, 3, 4, 4, 4};

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic pix_t mk(input int x, input int y, input logic [23:0] c);
    return {x[9:0], y[8:0], c};
  endfunction

  function automatic pix_t cur_pix();
    return {x_o, y_o, r_o, g_o, b_o};
  endfunction

  task automatic apb_write(input logic [31:0] d);
    int k;
    @(negedge clk);
    pSel_i = 1'b1; pWrite_i = 1'b1; pEnable_i = 1'b0; pDataWrite_i = d;
    @(negedge clk);
    pEnable_i = 1'b1;
    k = 0;
    while (!pReady_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("apb_write_ready", 64'(pReady_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    wr_cyc = cyc;
    pSel_i = 1'b0; pEnable_i = 1'b0; pWrite_i = 1'b0;
  endtask

  task automatic apb_read(output logic [31:0] d);
    @(negedge clk);
    pSel_i = 1'b1; pWrite_i = 1'b0; pEnable_i = 1'b0;
    #1;
    d = pDataRead_o;
    pSel_i = 1'b0;
  endtask

  // Every valid sample, stalled or not, must show the expected pixel for the next beat.
  task automatic collect(input int off, input int n, input bit toggle, input string tag);
    int k;
    bit stalled;
    k = 0; stalled = 1'b0; got_n = 0; first_cyc = -1;
    while (got_n < n && k < 400) begin
      @(negedge clk);
      pixel_ready_i = toggle ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
      if (pixel_valid_o) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check({tag, "_busy_during"}, 64'(busy_o), 64'd1);
        end
        check({tag, "_pixel"}, 64'(cur_pix()), 64'(pool[off + got_n]));
        if (pixel_ready_i) begin
          got_n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end else if (stalled) begin
        check({tag, "_valid_held"}, 64'(pixel_valid_o), 64'd1);
      end
      k++;
    end
    check({tag, "_count"}, 64'(got_n), 64'(n));
    pixel_ready_i = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_valid_after"}, 64'(pixel_valid_o), 64'd0);
    check({tag, "_busy_after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [31:0] st;
    int k, beats, last;

    for (int i = 0; i < 13; i++) pool[i]      = mk(l1x[i], l1y[i], 24'hAABD3E);
    for (int i = 0; i < 8; i++)  pool[13 + i] = mk(l2x[i], l2y[i], 24'h00FF00);
    for (int i = 0; i < 6; i++)  pool[21 + i] = mk(rcx[i], rcy[i], 24'h123456);
    pool[27] = mk(0, 0, 24'h112233);
    pool[28] = mk(3, 3, 24'h010203);

    prims[0] = '{32'h1000_0000, 32'h2000_1807, 32'h40AA_BD3E, 0, 13, 1'b0};
    prims[1] = '{32'h1000_0A09, 32'h2000_0602, 32'h4000_FF00, 13, 8, 1'b0};
    prims[2] = '{32'h1000_0804, 32'h2000_0403, 32'h8012_3456, 21, 6, 1'b0};
    prims[3] = '{32'h1000_0000, 32'h2000_1807, 32'h40AA_BD3E, 0, 13, 1'b1};

    n_rst = 1'b0;
    pAddr_i = '0; pDataWrite_i = '0;
    pSel_i = 1'b0; pEnable_i = 1'b0; pWrite_i = 1'b0;
    pixel_ready_i = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_pready", 64'(pReady_o), 64'd1);
    check("reset_valid", 64'(pixel_valid_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_pixel", 64'(cur_pix()), 64'd0);
    n_rst = 1'b1;
    apb_read(st);
    check("reset_status", 64'(st), 64'd0);

    for (int p = 0; p < 4; p++) begin
      apb_write(prims[p].xy1);
      apb_write(prims[p].xy2);
      apb_write(prims[p].cmd);
      collect(prims[p].off, prims[p].n, prims[p].toggle, $sformatf("prim%0d", p));
      if (p == 0) check("first_valid_latency", 64'(first_cyc - wr_cyc), 64'd2);
      check_idle($sformatf("prim%0d", p));
    end

    // FIFO fills while a line is stalled; the 5th write waits for the first pop.
    pixel_ready_i = 1'b0;
    apb_write(32'h1000_0000);
    apb_write(32'h2000_1807);
    apb_write(32'h40AA_BD3E);
    k = 0;
    while (!pixel_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("full_first_valid", 64'(pixel_valid_o), 64'd1);
    check("full_first_pixel", 64'(cur_pix()), 64'(pool[0]));
    apb_write(32'h1000_0603);
    apb_write(32'h2000_0603);
    apb_write(32'h0000_0000);
    apb_write(32'h7000_0000);
    apb_read(st);
    check("full_status", 64'(st), 64'h0000_0403);
    check("full_pready", 64'(pReady_o), 64'd0);
    @(negedge clk);
    pSel_i = 1'b1; pWrite_i = 1'b1; pEnable_i = 1'b0; pDataWrite_i = 32'h4001_0203;
    @(negedge clk);
    pEnable_i = 1'b1;
    check("full_wait_pready", 64'(pReady_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_wait_pready_hold", 64'(pReady_o), 64'd0);
      check("full_stall_pixel", 64'(cur_pix()), 64'(pool[0]));
    end
    pixel_ready_i = 1'b1;
    beats = 1; last = 0; k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (pReady_o) break;
      if (pixel_valid_o) begin
        check("full_drain_pixel", 64'(cur_pix()), 64'(pool[(beats < 13) ? beats : 12]));
        beats++;
        last = k;
      end
    end
    check("full_drain_count", 64'(beats), 64'd13);
    check("full_pready_gap", 64'(k - last), 64'd2);
    check("full_pready_rise", 64'(pReady_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    pSel_i = 1'b0; pEnable_i = 1'b0; pWrite_i = 1'b0;
    collect(28, 1, 1'b0, "queued_draw");
    check_idle("queued_draw");

    // Reset during the 4th pixel of (5,9)->(12,7), with a command still queued.
    pixel_ready_i = 1'b0;
    apb_write(32'h1000_0A09);
    apb_write(32'h2000_1807);
    apb_write(32'h40AA_BD3E);
    apb_write(32'h0000_0000);
    apb_read(st);
    check("rst_pre_status", 64'(st), 64'h0000_0101);
    beats = 0; k = 0;
    while (beats < 3 && k < 50) begin
      @(negedge clk);
      pixel_ready_i = 1'b1;
      if (pixel_valid_o) beats++;
      k++;
    end
    @(negedge clk);
    check("rst_4th_pixel", 64'(cur_pix()), 64'(mk(8, 8, 24'hAABD3E)));
    check("rst_4th_valid", 64'(pixel_valid_o), 64'd1);
    n_rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(pixel_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_pready", 64'(pReady_o), 64'd1);
    check("rst_pixel", 64'(cur_pix()), 64'd0);
    pSel_i = 1'b1; pWrite_i = 1'b0;
    #1;
    check("rst_status", 64'(pDataRead_o), 64'd0);
    pSel_i = 1'b0;
    n_rst = 1'b1;
    apb_write(32'h4011_2233);
    collect(27, 1, 1'b0, "post_reset_line");
    check_idle("post_reset_line");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpu_raster_engine.md
Name: gpu_raster_engine

Overview:
- Parametrised successor to the single-line GPU draw path.
- APB-programmed rasteriser: commands are written into a command FIFO, then executed in order.
- Executes Bresenham lines in all octants and filled axis-aligned rectangles.
- Emits one pixel per accepted valid/ready beat toward the framebuffer writer, with backpressure.

Parameters:
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- COLOR_W, 8, per-channel colour width; 3*COLOR_W <= 28 required
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous, active-low
- pAddr_i  in  32  APB address (decoded externally; ignored)
- pDataWrite_i  in  32  APB write data (command word)
- pSel_i  in  1  APB select
- pEnable_i  in  1  APB enable
- pWrite_i  in  1  APB write strobe
- pReady_o  out  1  APB ready; low while FIFO full
- pDataRead_o  out  32  status word
- x_o  out  X_W  pixel x
- y_o  out  Y_W  pixel y
- r_o, g_o, b_o  out  COLOR_W each  pixel colour
- pixel_valid_o  out  1  pixel beat valid
- pixel_ready_i  in  1  downstream accepts beat
- busy_o  out  1  FIFO non-empty or drawing

Behaviour:
- Reset (n_rst low at a clk edge): FIFO emptied; XY1/XY2 set to (0,0); state IDLE. All outputs 0, except pReady_o=1. This applies mid-draw too: the current primitive is abandoned, and pixel_valid_o drops on that edge.
- APB write accept: pSel_i & pEnable_i & pWrite_i & pReady_o. The word is pushed at that edge.
- pReady_o = !fifo_full (combinational). A full FIFO inserts wait states; the write completes the edge after a pop frees a slot.
- APB read (pSel_i & !pWrite_i): pDataRead_o = {16'b0, level[7:0], 6'b0, fifo_full, busy_o}.
- Command word fields: opcode = [31:28]; x = [X_W+Y_W-1:Y_W]; y = [Y_W-1:0]. Colour is r=[3C-1:2C], g=[2C-1:C], b=[C-1:0], where C=COLOR_W.
- Opcodes:
  - 0x1 SET_XY1
  - 0x2 SET_XY2
  - 0x4 DRAW_LINE, using the colour field
  - 0x8 FILL_RECT, using the colour field
  - Any other value: popped and discarded in 1 cycle.
- States:
  - IDLE: if FIFO non-empty, pop. SET_XY1 and SET_XY2 update their register at the pop edge and stay in IDLE. DRAW_LINE goes to LINE_SETUP. FILL_RECT goes to RECT_SETUP.
  - LINE_SETUP: latch dx=|x2-x1| and dy=|y2-y1| (width max(X_W,Y_W)+1, signed), sx/sy step signs, and err=dx-dy; cur=XY1. Go to LINE.
  - LINE: present cur with valid=1. On a valid&ready edge: if cur==XY2, go to IDLE (valid=0). Otherwise apply the Bresenham step: e2=2*err; if e2>-dy then err-=dy, x+=sx; if e2<dx then err+=dx, y+=sy.
  - RECT_SETUP: xmin/xmax and ymin/ymax are computed from XY1 and XY2 in either corner order; cur=(xmin,ymin). Go to RECT.
  - RECT: raster order, x increments first. At xmax, x returns to xmin and y increments. After the beat at (xmax,ymax) is accepted, go to IDLE.
- Latency: write edge E0 into an empty FIFO in IDLE gives pop at E1, setup at E2, and pixel_valid_o high after E2.
- Throughput: 1 pixel/cycle while pixel_ready_i=1.
- Back-to-back primitives: one IDLE pop cycle plus one setup cycle between the last beat and the next first beat.
- Backpressure: while valid & !ready, x_o, y_o and colour are held stable. pixel_valid_o never drops without acceptance, except on reset.
- Pixel count: lines emit max(dx,dy)+1 pixels, inclusive of both endpoints. XY1==XY2 emits exactly 1 pixel. Rects emit (xmax-xmin+1)*(ymax-ymin+1) pixels.
- Coordinate registers keep their values after draws; DRAW commands reuse the last XY1/XY2.
- busy_o = (state!=IDLE) | !fifo_empty.
- Push and pop on the same edge are both honoured; level is unchanged.

Test Plan:
- Reset, then writes 0x10000000, 0x20001807, 0x40AABD3E, ready=1 -> 13 pixels from (0,0) to (12,7), each with r=0xAA, g=0xBD, b=0x3E; first valid 2 cycles after the draw write edge; busy_o falls after the last beat.
- XY1=(5,9), XY2=(3,2), DRAW_LINE colour 0x00FF00 (steep, negative steps) -> 8 pixels, y from 9 down to 2, x monotonically non-increasing from 5 to 3, last pixel exactly (3,2).
- XY1=(4,4), XY2=(2,3), FILL_RECT 0x123456 -> 6 pixels in order (2,3), (3,3), (4,3), (2,4), (3,4), (4,4).
- Same line as the first test with pixel_ready_i toggled 1,0,0,1 repeating -> 13 pixels, none dropped or duplicated; outputs stable during every stall cycle.
- Hold ready=0 with a draw active, then issue 5 further writes (FIFO_DEPTH=4) -> pReady_o low on the 5th write; pDataRead_o[1]=1 with level 4; the 5th write completes the edge after the next pop.
- n_rst low for 1 cycle during the 4th pixel of a line -> next cycle all outputs 0, pixel_valid_o=0, busy_o=0, FIFO level 0; a subsequent DRAW_LINE starts from (0,0).
